// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//   Loadable down-counter / interval timer used to time map-decoder scan
//   windows. A start value N is taken over a valid/ready handshake while idle.
//   The counter then decrements on every enabled cycle. When it reaches zero it
//   emits a one-cycle registered done pulse.
//
//   Build option:
//     AUTO_RELOAD_EN  When defined, the terminal count reloads the start value
//                     and the timer stays in RUN. It then gives a periodic done
//                     every N enabled cycles. When undefined, the timer is
//                     one-shot: the terminal count returns it to IDLE with
//                     count 0.
//
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous, active-low reset
//     load_valid  load request, qualifies load_value
//     load_ready  high while idle; a load is taken on load_valid && load_ready
//     load_value  start value N
//     enable      count enable; RUN holds count while low
//     abort       synchronous cancel back to IDLE; overrides load and terminal
//     count       current counter value (registered)
//     busy        high while running
//     done        one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module down_counter_timer #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic             done_nxt;

    assign load_ready = (state == IDLE);
    assign busy       = (state == RUN);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;

        if (abort) begin
            // Cancel wins over everything, including a load offered in IDLE
            // and a terminal count in RUN.
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        if (load_value == '0) begin
                            // Zero-length interval completes immediately
                            // without ever entering RUN.
                            count_nxt = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            count_nxt  = load_value;
                            reload_nxt = load_value;
                            state_nxt  = RUN;
                        end
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (count > WIDTH'(1)) begin
                            count_nxt = count - WIDTH'(1);
                        end else if (count == WIDTH'(1)) begin
                            done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                            count_nxt = reload_reg;
`else
                            count_nxt = '0;
                            state_nxt = IDLE;
`endif
                        end else begin
                            // count==0 in RUN is unreachable. Never wrap
                            // below zero; fall back to IDLE.
                            count_nxt = '0;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
//   Directed bench for down_counter_timer. A reference model tracks the loaded
//   interval N and the number of enabled cycles spent in it. The expected count
//   while running is N - ticks, and 0 otherwise. A compare process checks every
//   output on each falling edge. Directed tests add hand-computed literal
//   checks. Build with AUTO_RELOAD_EN defined to exercise the periodic mode.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

    localparam int W = 13;
`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_value = '0;
    logic         enable = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .enable     (enable),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_run   = 1'b0;
    int m_n     = 0;
    int m_ticks = 0;
    bit m_done  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run   <= 1'b0;
            m_n     <= 0;
            m_ticks <= 0;
            m_done  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (abort) begin
                m_run   <= 1'b0;
                m_ticks <= 0;
            end else if (!m_run) begin
                if (load_valid) begin
                    if (load_value == 0) begin
                        m_done <= 1'b1;
                    end else begin
                        m_run   <= 1'b1;
                        m_n     <= int'(load_value);
                        m_ticks <= 0;
                    end
                end
            end else if (enable) begin
                if (m_ticks + 1 == m_n) begin
                    m_done  <= 1'b1;
                    m_ticks <= 0;
                    if (!AUTO) m_run <= 1'b0;
                end else begin
                    m_ticks <= m_ticks + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("count", int'(count), m_run ? (m_n - m_ticks) : 0);
        chk("busy", int'(busy), int'(m_run));
        chk("load_ready", int'(load_ready), int'(!m_run));
        chk("done", int'(done), int'(m_done));
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        load_valid = 1'b1;
        load_value = W'(n);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_abort;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int exp3 [7];
        int n;
        exp3 = '{3, 3, 2, 2, 1, 1, 0};
        exp3[6] = AUTO ? 4 : 0;

        // Reset state
        repeat (2) tick();
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(load_ready), 1);
        chk("rst_done", int'(done), 0);
        reset = 1'b1;
        tick();

        // 1: async reset mid-run at count 7
        enable = 1'b1;
        load(10);
        repeat (3) tick();
        chk("t1_pre", int'(count), 7);
        reset = 1'b0;
        #1;
        chk("t1_count", int'(count), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_ready", int'(load_ready), 1);
        chk("t1_done", int'(done), 0);
        tick();
        reset = 1'b1;
        tick();

        // 2: load 5 with enable high; a load offered mid-run is ignored
        enable = 1'b1;
        load(5);
        chk("t2_load", int'(count), 5);
        chk("t2_busy", int'(busy), 1);
        for (int i = 4; i >= 1; i--) begin
            if (i == 3) begin
                load_valid = 1'b1;
                load_value = W'(9);
            end
            tick();
            load_valid = 1'b0;
            chk("t2_count", int'(count), i);
            chk("t2_nodone", int'(done), 0);
        end
        tick();
        chk("t2_done", int'(done), 1);
        chk("t2_end", int'(count), AUTO ? 5 : 0);
        chk("t2_ready", int'(load_ready), AUTO ? 0 : 1);
        tick();
        chk("t2_pulse", int'(done), 0);
        do_abort();

        // 3: enable alternating 1,0,1,0...
        enable = 1'b0;
        load(4);
        for (int i = 0; i < 7; i++) begin
            enable = (i % 2 == 0);
            tick();
            chk("t3_count", int'(count), exp3[i]);
            chk("t3_done", int'(done), (i == 6) ? 1 : 0);
        end
        enable = 1'b0;
        do_abort();

        // 4: zero load, then full-range load
        load(0);
        chk("t4_zdone", int'(done), 1);
        chk("t4_zbusy", int'(busy), 0);
        chk("t4_zcount", int'(count), 0);
        tick();
        chk("t4_zpulse", int'(done), 0);
        enable = 1'b1;
        load(8191);
        chk("t4_max", int'(count), 8191);
        n = 0;
        while (!done && n < 9000) begin
            tick();
            n++;
        end
        chk("t4_latency", n, 8191);
        chk("t4_end", int'(count), AUTO ? 8191 : 0);
        do_abort();

        // 5: abort mid-run, abort at terminal count, abort+load in IDLE
        enable = 1'b1;
        load(6);
        repeat (3) tick();
        chk("t5_at3", int'(count), 3);
        do_abort();
        chk("t5_count", int'(count), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        load(3);
        repeat (2) tick();
        chk("t5_at1", int'(count), 1);
        do_abort();
        chk("t5_term_done", int'(done), 0);
        chk("t5_term_count", int'(count), 0);
        chk("t5_term_ready", int'(load_ready), 1);
        abort      = 1'b1;
        load_valid = 1'b1;
        load_value = W'(5);
        tick();
        abort      = 1'b0;
        load_valid = 1'b0;
        chk("t5_al_busy", int'(busy), 0);
        chk("t5_al_count", int'(count), 0);
        tick();
        chk("t5_al_idle", int'(busy), 0);

`ifdef AUTO_RELOAD_EN
        // 6: periodic reload 3,2,1,3,2,1...
        enable = 1'b1;
        load(3);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("t6_count", int'(count), 3 - ((k + 1) % 3));
            chk("t6_done", int'(done), (k % 3 == 2) ? 1 : 0);
            chk("t6_ready", int'(load_ready), 0);
        end
        do_abort();
`endif

        enable = 1'b0;
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
